op_mode_scheduler: RTL and testbench

//  Owns the shared 6-bit operation datapath (op select + input bits -> 42-bit, 6-digit
//  7-segment word). Debounces two push buttons, steps or auto-cycles operation 1..6,

---
 rtl/op_mode_scheduler.sv | 150 +++++++++++++++
 tb/tb_op_mode_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_mode_scheduler.sv
// rtl/op_mode_scheduler.sv - debounced op stepper/auto-cycler driving the shared 7-seg op datapath
module op_mode_scheduler #(
  parameter int DEB_CYCLES = 250000,
  parameter int TICK_DIV   = 50000000,
  parameter int SETTLE     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  bits_in,
  input  logic        btn_next,
  input  logic        btn_auto,
  input  logic [41:0] op_display_in,
  output logic [2:0]  op_sel,
  output logic [5:0]  op_bits,
  output logic [41:0] display,
  output logic        disp_valid,
  output logic [5:0]  op_led,
  output logic        auto_on
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [DW-1:0] DEB_MAX     = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX    = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SHOW
  } state_t;

  state_t        state;
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    level;
  logic [1:0]    level_q;
  logic [DW-1:0] deb_cnt [2];
  logic          next_ev;
  logic          auto_ev;
  logic [TW-1:0] tick_cnt;
  logic          tick_ev;
  logic          adv_req;
  logic [SW-1:0] settle_cnt;
  logic [2:0]    sel_next;

  // bit 0 is the step button, bit 1 the auto-mode button
  assign btn_raw = {btn_auto, btn_next};

  // two-flop synchronizers for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // stable-count filter: a level is accepted after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= '0;
      level_q    <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      level_q <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign next_ev = level[0] & ~level_q[0];
  assign auto_ev = level[1] & ~level_q[1];
  assign tick_ev = auto_on && (tick_cnt == TICK_MAX);
  assign adv_req = next_ev | tick_ev;

  // auto mode toggle and free-running tick divider (restarted on every toggle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_on  <= 1'b0;
      tick_cnt <= '0;
    end else if (auto_ev) begin
      auto_on  <= ~auto_on;
      tick_cnt <= '0;
    end else if (auto_on) begin
      tick_cnt <= tick_ev ? '0 : tick_cnt + TW'(1);
    end
  end

  // next op number: first request after reset keeps op 1, later ones step 1..6 with wrap
  always_comb begin
    sel_next = op_sel;
    if (state == ST_SHOW) begin
      sel_next = (op_sel == 3'd6) ? 3'd1 : op_sel + 3'd1;
    end
  end

  // op FSM; op_sel/op_bits are loaded on the edge entering LOAD so the datapath
  // starts settling immediately, and LOAD counts as the first settle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_sel     <= 3'd1;
      op_bits    <= '0;
      op_led     <= 6'b000001;
      display    <= '0;
      disp_valid <= 1'b0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_SHOW: begin
          if (adv_req) begin
            op_sel     <= sel_next;
            op_led     <= 6'b000001 << (sel_next - 3'd1);
            op_bits    <= bits_in;
            disp_valid <= 1'b0;
            settle_cnt <= SETTLE_INIT;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD, ST_SETTLE: begin
          if (settle_cnt == '0) begin
            display    <= op_display_in;
            disp_valid <= 1'b1;
            state      <= ST_SHOW;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_mode_scheduler.sv
// tb/tb_op_mode_scheduler.sv - randomized and directed self-checking bench for op_mode_scheduler
module tb_op_mode_scheduler;

  localparam int DEB_CYCLES = 4;
  localparam int TICK_DIV   = 16;
  localparam int SETTLE     = 2;

  logic        clk;
  logic        rst_n;
  logic [5:0]  bits_in;
  logic        btn_next;
  logic        btn_auto;
  logic [41:0] op_display_in;
  logic [2:0]  op_sel;
  logic [5:0]  op_bits;
  logic [41:0] display;
  logic        disp_valid;
  logic [5:0]  op_led;
  logic        auto_on;

  int tests = 0;
  int fails = 0;

  op_mode_scheduler #(
    .DEB_CYCLES(DEB_CYCLES),
    .TICK_DIV  (TICK_DIV),
    .SETTLE    (SETTLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bits_in      (bits_in),
    .btn_next     (btn_next),
    .btn_auto     (btn_auto),
    .op_display_in(op_display_in),
    .op_sel       (op_sel),
    .op_bits      (op_bits),
    .display      (display),
    .disp_valid   (disp_valid),
    .op_led       (op_led),
    .auto_on      (auto_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in for the shared datapath; op 1 with 101101 yields the reference word
  function automatic logic [41:0] dp(input logic [2:0] s, input logic [5:0] b);
    logic [8:0] x;
    x = {s - 3'd1, b ^ 6'b101101};
    return 42'h155_5555_5555 ^ (42'(x) * 42'h001_0040_1001);
  endfunction

  assign op_display_in = dp(op_sel, op_bits);

  // behavioural model state
  int          m_sel;
  logic [5:0]  m_bits;
  logic [41:0] m_disp;
  bit          m_valid;
  bit          m_auto;
  bit          m_started;
  int          m_tick;
  int          m_busy;
  bit          m_lvl [2];
  bit          m_ev  [2];
  logic [7:0]  m_hist [2];

  task automatic model_reset();
    m_sel = 1; m_bits = '0; m_disp = '0; m_valid = 0; m_auto = 0;
    m_started = 0; m_tick = 0; m_busy = 0;
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_ev[i] = 0; m_hist[i] = '0;
    end
  endtask

  task automatic model_step();
    bit adv;
    bit flip;
    bit raw [2];
    raw[0] = btn_next;
    raw[1] = btn_auto;
    adv = m_ev[0] || (m_auto && m_tick == TICK_DIV - 1);
    if (m_ev[1]) begin
      m_auto = !m_auto;
      m_tick = 0;
    end else if (m_auto) begin
      m_tick = (m_tick + 1) % TICK_DIV;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_disp  = dp(3'(m_sel), m_bits);
        m_valid = 1;
      end
    end else if (adv) begin
      if (m_started) m_sel = m_sel % 6 + 1;
      m_started = 1;
      m_bits    = bits_in;
      m_valid   = 0;
      m_busy    = SETTLE;
    end
    // hist[k] is the raw sample taken k edges ago; synchronizer adds one more edge
    for (int i = 0; i < 2; i++) begin
      flip = 1;
      for (int j = 1; j <= DEB_CYCLES; j++) if (m_hist[i][j] == m_lvl[i]) flip = 0;
      m_ev[i] = flip && !m_lvl[i];
      if (flip) m_lvl[i] = !m_lvl[i];
      m_hist[i] = {m_hist[i][6:0], raw[i]};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_op_sel", 64'(op_sel), 64'(m_sel));
      chk("cmp_op_bits", 64'(op_bits), 64'(m_bits));
      chk("cmp_display", 64'(display), 64'(m_disp));
      chk("cmp_disp_valid", 64'(disp_valid), 64'(m_valid));
      chk("cmp_op_led", 64'(op_led), 64'(6'b000001 << (m_sel - 1)));
      chk("cmp_auto_on", 64'(auto_on), 64'(m_auto));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    cycle(8);
    btn_next = 1'b0;
    cycle(8);
  endtask

  task automatic press_auto();
    btn_auto = 1'b1;
    cycle(8);
    btn_auto = 1'b0;
    cycle(8);
  endtask

  task automatic count_changes(input int n, output int changes);
    logic [2:0] prev;
    prev    = op_sel;
    changes = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (op_sel != prev) changes++;
      prev = op_sel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int val);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_tick == val) ok = 1;
      else cycle(1);
    end
    chk("wait_tick_phase", 64'(ok), 64'd1);
  endtask

  logic [2:0] wrap_seq [7];
  int         changes;
  int         hold_n;
  int         hold_a;
  bit         found;

  initial begin
    rst_n    = 1'b0;
    bits_in  = '0;
    btn_next = 1'b0;
    btn_auto = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 10; i++) begin
      bits_in  = 6'($urandom);
      btn_next = 1'($urandom);
      btn_auto = 1'($urandom);
      cycle(1);
    end
    chk("rst_op_sel", 64'(op_sel), 64'd1);
    chk("rst_display", 64'(display), 64'd0);
    chk("rst_disp_valid", 64'(disp_valid), 64'd0);
    chk("rst_auto_on", 64'(auto_on), 64'd0);
    btn_next = 1'b0;
    btn_auto = 1'b0;
    rst_n    = 1'b1;
    cycle(100);
    chk("idle_op_sel", 64'(op_sel), 64'd1);
    chk("idle_display", 64'(display), 64'd0);
    chk("idle_disp_valid", 64'(disp_valid), 64'd0);
    chk("idle_auto_on", 64'(auto_on), 64'd0);

    // single step with exact capture latency
    bits_in  = 6'b101101;
    btn_next = 1'b1;
    found    = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (op_bits == 6'b101101) found = 1;
    end
    chk("step_load_seen", 64'(found), 64'd1);
    chk("step_op_sel", 64'(op_sel), 64'd1);
    @(negedge clk);
    chk("step_valid_low", 64'(disp_valid), 64'd0);
    @(negedge clk);
    chk("step_valid_high", 64'(disp_valid), 64'd1);
    chk("step_display", 64'(display), 64'h155_5555_5555);
    @(posedge clk);
    #1;
    cycle(4);
    btn_next = 1'b0;
    cycle(10);

    // bounce then hold: one advance
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      cycle(2);
    end
    btn_next = 1'b1;
    cycle(10);
    btn_next = 1'b0;
    cycle(10);
    chk("bounce_one_adv", 64'(op_sel), 64'd2);

    // seven clean presses with wrap
    wrap_seq = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3};
    for (int i = 0; i < 7; i++) begin
      press_next();
      chk("wrap_seq", 64'(op_sel), 64'(wrap_seq[i]));
    end

    // auto mode
    press_auto();
    chk("auto_on_set", 64'(auto_on), 64'd1);
    count_changes(64, changes);
    chk("auto_adv_count", 64'(changes), 64'd4);

    // next_ev coincident with tick_ev
    wait_tick(9);
    btn_next = 1'b1;
    count_changes(12, changes);
    chk("collide_single", 64'(changes), 64'd1);
    btn_next = 1'b0;
    cycle(8);

    // next_ev lands in LOAD right after a tick advance: dropped
    wait_tick(10);
    btn_next = 1'b1;
    count_changes(12, changes);
    chk("drop_in_load", 64'(changes), 64'd1);
    btn_next = 1'b0;
    cycle(8);

    press_auto();
    chk("auto_on_clear", 64'(auto_on), 64'd0);
    cycle(4);
    count_changes(64, changes);
    chk("auto_off_quiet", 64'(changes), 64'd0);

    // reset one cycle after LOAD
    bits_in  = 6'b010011;
    btn_next = 1'b1;
    found    = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (op_bits == 6'b010011) found = 1;
    end
    chk("mid_load_seen", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    btn_next = 1'b0;
    #1;
    chk("async_op_sel", 64'(op_sel), 64'd1);
    chk("async_op_bits", 64'(op_bits), 64'd0);
    chk("async_display", 64'(display), 64'd0);
    chk("async_disp_valid", 64'(disp_valid), 64'd0);
    chk("async_op_led", 64'(op_led), 64'd1);
    chk("async_auto_on", 64'(auto_on), 64'd0);
    cycle(3);
    rst_n = 1'b1;
    cycle(20);
    chk("no_capture_disp", 64'(display), 64'd0);
    chk("no_capture_valid", 64'(disp_valid), 64'd0);

    // randomized phase, checked every cycle by the model compare
    hold_n = 0;
    hold_a = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold_n == 0) begin
        btn_next = 1'($urandom);
        hold_n   = $urandom_range(1, 12);
      end
      hold_n--;
      if (hold_a == 0) begin
        btn_auto = ($urandom_range(0, 3) == 0);
        hold_a   = $urandom_range(1, 12);
      end
      hold_a--;
      if ($urandom_range(0, 3) == 0) bits_in = 6'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cycle(2);
        rst_n = 1'b1;
      end
      cycle(1);
    end

    cycle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
